// File: rtl/mem_arbiter_pkg.sv
// Shared cache/memory bundle types and arbiter constants.
package cache_definition;

    typedef struct packed {
        logic        valid;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
    } cache_to_mem_type;

    typedef struct packed {
        logic        ready;
        logic [31:0] data;
    } mem_to_cache_type;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_state_type;

    localparam logic [31:0] ARB_ERR_DATA = 32'hDEAD_BEEF;
    localparam int ARB_NUM_REQ = 2;

    typedef cache_to_mem_type [ARB_NUM_REQ-1:0] cache_to_mem_arr_t;
    typedef mem_to_cache_type [ARB_NUM_REQ-1:0] mem_to_cache_arr_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and controller-side bundle of the memory arbiter.
interface mem_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import cache_definition::*;

    cache_to_mem_type [NUM_REQ-1:0] req_in;
    mem_to_cache_type [NUM_REQ-1:0] resp_out;
    cache_to_mem_type               mem_req;
    mem_to_cache_type               mem_resp;
    logic [$clog2(NUM_REQ)-1:0]     grant_id;
    logic                           busy;
    logic                           timeout_err;

    // slave = the arbiter, master = caches plus memory controller
    modport slave (
        input  req_in, mem_resp,
        output resp_out, mem_req, grant_id, busy, timeout_err
    );

    modport master (
        output req_in, mem_resp,
        input  resp_out, mem_req, grant_id, busy, timeout_err
    );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin search: first eligible index at or after rr_ptr.
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IW-1:0]      rr_ptr,
    output logic               found,
    output logic [IW-1:0]      index
);

    function automatic logic [IW-1:0] wrap(input logic [IW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IW'(s);
    endfunction

    // Walk from the far end so the closest match to rr_ptr wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (eligible[wrap(rr_ptr, k)]) begin
                found = 1'b1;
                index = wrap(rr_ptr, k);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory controller port between caches,
// one transaction in flight, with a watchdog abort.
module mem_arbiter
    import cache_definition::*;
#(
    parameter int          NUM_REQ  = 2,
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = ARB_ERR_DATA
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int WW = $clog2(TIMEOUT + 1);

    arb_state_type    state, state_n;
    cache_to_mem_type hold;
    logic [IW-1:0]    grant, rr_ptr, pick;
    logic [NUM_REQ-1:0] mask, elig;
    logic [WW-1:0]    wdog;
    logic             found, fin, abort, terr;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++)
            elig[i] = bus.req_in[i].valid && !mask[i];
    end

    rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
        .eligible (elig),
        .rr_ptr   (rr_ptr),
        .found    (found),
        .index    (pick)
    );

    assign abort = (state == WAIT) && !bus.mem_resp.ready
                   && (wdog == WW'(TIMEOUT - 1));
    assign fin   = ((state == WAIT) && bus.mem_resp.ready) || abort;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (found) state_n = ISSUE;
            ISSUE:   state_n = WAIT;
            WAIT:    if (fin) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            hold   <= '0;
            grant  <= '0;
            rr_ptr <= '0;
            mask   <= '0;
            wdog   <= '0;
            terr   <= 1'b0;
        end else begin
            state <= state_n;
            mask  <= '0;
            if (state == IDLE && found) begin
                hold  <= bus.req_in[pick];
                grant <= pick;
            end
            if (state == WAIT) wdog <= wdog + 1'b1;
            if (fin)
                rr_ptr <= (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            if (abort) terr <= 1'b1;
            // Hide the just-served requester for one IDLE cycle only.
            if (state == DONE) begin
                mask <= NUM_REQ'(1) << grant;
                wdog <= '0;
            end
        end
    end

    assign bus.mem_req = '{
        valid: hold.valid && (state == ISSUE),
        rw:    hold.rw,
        addr:  hold.addr,
        data:  hold.data
    };

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.resp_out[i].ready = fin && (grant == IW'(i));
            bus.resp_out[i].data  = abort ? ERR_DATA : bus.mem_resp.data;
        end
    end

    assign bus.grant_id    = grant;
    assign bus.busy        = (state != IDLE);
    assign bus.timeout_err = terr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency memory model.
module tb_mem_arbiter;
    import cache_definition::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.NUM_REQ(2)) bus ();

    cache_to_mem_type [1:0] req;
    logic        m_ready = 1'b0;
    logic [31:0] m_rdata = '0;
    int          mem_delay = 2;
    int          mcnt = 0;
    int          tests = 0;
    int          fails = 0;

    assign bus.req_in   = req;
    assign bus.mem_resp = '{ready: m_ready, data: m_rdata};

    mem_arbiter #(
        .NUM_REQ  (2),
        .TIMEOUT  (16),
        .ERR_DATA (32'hDEAD_BEEF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Controller model: ready pulses mem_delay cycles after the ISSUE cycle.
    always @(posedge clk) begin
        #1;
        m_ready = 1'b0;
        if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) m_ready = 1'b1;
        end
        if (bus.mem_req.valid && mem_delay > 0) mcnt = mem_delay;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        bit got;
        req = '0;
        tick();
        tick();
        check("rst_busy", bus.busy, 0);
        check("rst_grant", bus.grant_id, 0);
        check("rst_memreq", bus.mem_req, 0);
        check("rst_rdy0", bus.resp_out[0].ready, 0);
        check("rst_rdy1", bus.resp_out[1].ready, 0);
        check("rst_terr", bus.timeout_err, 0);
        rst = 1'b1;
        tick();
        check("idle_busy", bus.busy, 0);

        // single read by requester 0
        m_rdata = 32'h1234_5678;
        req[0] = '{valid: 1'b1, rw: 1'b0, addr: 32'h40, data: 32'h0};
        tick();
        check("rd_issue_v", bus.mem_req.valid, 1);
        check("rd_issue_a", bus.mem_req.addr, 32'h40);
        check("rd_grant", bus.grant_id, 0);
        check("rd_busy", bus.busy, 1);
        tick();
        check("rd_wait_v", bus.mem_req.valid, 0);
        check("rd_wait_a", bus.mem_req.addr, 32'h40);
        check("rd_wait_rdy", bus.resp_out[0].ready, 0);
        tick();
        check("rd_rdy0", bus.resp_out[0].ready, 1);
        check("rd_data0", bus.resp_out[0].data, 32'h1234_5678);
        check("rd_rdy1", bus.resp_out[1].ready, 0);
        check("rd_data1", bus.resp_out[1].data, 32'h1234_5678);
        req[0] = '0;
        tick();
        check("rd_done_rdy", bus.resp_out[0].ready, 0);
        check("rd_done_busy", bus.busy, 1);
        tick();
        check("rd_idle", bus.busy, 0);

        // timeout on requester 1: memory never answers
        mem_delay = 0;
        req[1] = '{valid: 1'b1, rw: 1'b0, addr: 32'h80, data: 32'h0};
        tick();
        check("to_grant", bus.grant_id, 1);
        check("to_issue", bus.mem_req.valid, 1);
        repeat (15) tick();
        check("to_pre_rdy", bus.resp_out[1].ready, 0);
        check("to_pre_err", bus.timeout_err, 0);
        tick();
        check("to_rdy", bus.resp_out[1].ready, 1);
        check("to_data", bus.resp_out[1].data, 32'hDEAD_BEEF);
        check("to_rdy0", bus.resp_out[0].ready, 0);
        req[1] = '0;
        tick();
        check("to_err", bus.timeout_err, 1);
        tick();
        repeat (3) tick();
        check("to_sticky", bus.timeout_err, 1);
        check("to_idle", bus.busy, 0);

        // reset in the middle of WAIT, late ready must be ignored
        mem_delay = 3;
        req[0] = '{valid: 1'b1, rw: 1'b1, addr: 32'h44, data: 32'h55};
        tick();
        check("mr_issue", bus.mem_req.valid, 1);
        tick();
        check("mr_wait", bus.busy, 1);
        req[0] = '0;
        rst = 1'b0;
        #1;
        check("mr_busy", bus.busy, 0);
        check("mr_memreq", bus.mem_req, 0);
        check("mr_terr", bus.timeout_err, 0);
        tick();
        rst = 1'b1;
        tick();
        check("mr_late_rdy", bus.resp_out[0].ready, 0);
        check("mr_late_busy", bus.busy, 0);
        tick();

        // contention: read by 0, write by 1, same cycle
        mem_delay = 2;
        m_rdata = 32'h0BAD_F00D;
        req[0] = '{valid: 1'b1, rw: 1'b0, addr: 32'h10, data: 32'h0};
        req[1] = '{valid: 1'b1, rw: 1'b1, addr: 32'h20, data: 32'hA5A5_A5A5};
        tick();
        check("ct_grant0", bus.grant_id, 0);
        check("ct_addr0", bus.mem_req.addr, 32'h10);
        check("ct_rw0", bus.mem_req.rw, 0);
        tick();
        tick();
        check("ct_rdy0", bus.resp_out[0].ready, 1);
        check("ct_rdy1_lo", bus.resp_out[1].ready, 0);
        req[0] = '0;
        tick();
        tick();
        check("ct_gap", bus.busy, 0);
        tick();
        check("ct_grant1", bus.grant_id, 1);
        check("ct_v1", bus.mem_req.valid, 1);
        check("ct_rw1", bus.mem_req.rw, 1);
        check("ct_addr1", bus.mem_req.addr, 32'h20);
        check("ct_wdata", bus.mem_req.data, 32'hA5A5_A5A5);
        tick();
        tick();
        check("ct_rdy1", bus.resp_out[1].ready, 1);
        req[1] = '0;
        tick();
        tick();

        // fairness: both valid for six transactions
        req[0] = '{valid: 1'b1, rw: 1'b0, addr: 32'h100, data: 32'h0};
        req[1] = '{valid: 1'b1, rw: 1'b0, addr: 32'h200, data: 32'h0};
        for (int n = 0; n < 6; n++) begin
            got = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                tick();
                if (bus.resp_out[0].ready || bus.resp_out[1].ready) got = 1'b1;
            end
            check("fair_seen", got, 1);
            check("fair_grant", bus.grant_id, n % 2);
            check("fair_onehot",
                  {bus.resp_out[1].ready, bus.resp_out[0].ready},
                  (n % 2) ? 2'b10 : 2'b01);
            if (n == 5) req = '0;
        end
        tick();
        tick();

        // mask: requester 0 keeps valid through DONE and first IDLE
        req[0] = '{valid: 1'b1, rw: 1'b0, addr: 32'h300, data: 32'h0};
        tick();
        tick();
        tick();
        check("mk_rdy", bus.resp_out[0].ready, 1);
        tick();
        tick();
        tick();
        check("mk_no_dup", bus.busy, 0);
        req[0] = '0;
        tick();
        check("mk_still_idle", bus.busy, 0);

        // mask: requester 1 lingers while 0 becomes pending
        req[1] = '{valid: 1'b1, rw: 1'b0, addr: 32'h400, data: 32'h0};
        tick();
        check("mb_grant1", bus.grant_id, 1);
        tick();
        tick();
        check("mb_rdy1", bus.resp_out[1].ready, 1);
        tick();
        req[0] = '{valid: 1'b1, rw: 1'b0, addr: 32'h500, data: 32'h0};
        tick();
        tick();
        check("mb_grant0", bus.grant_id, 0);
        check("mb_v0", bus.mem_req.valid, 1);
        check("mb_addr0", bus.mem_req.addr, 32'h500);
        req[1] = '0;
        tick();
        tick();
        check("mb_rdy0", bus.resp_out[0].ready, 1);
        req[0] = '0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
